// File: rtl/tinyrv_pkg.sv
// Shared TinyRISC-V datapath definitions: machine word width and word type.
package tinyrv_pkg;

    localparam int XLEN        = 32;
    localparam int MAX_LATENCY = 16;

    typedef logic [XLEN-1:0] word_t;

endpackage : tinyrv_pkg

// File: rtl/pipe_reg.sv
// Single pipeline register stage with asynchronous active-high reset to RESET_VAL.
module pipe_reg
    import tinyrv_pkg::*;
#(
    parameter int               WIDTH     = XLEN,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // NOTE: non-blocking assignment so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : pipe_reg

// File: rtl/module_name.sv
// Fixed-latency delay line: data_o is data_i registered through LATENCY pipe_reg stages.
// The reset input is active-high even though the port is named rst_n.
module module_name
    import tinyrv_pkg::*;
#(
    parameter int               WIDTH     = XLEN,
    parameter int               LATENCY   = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
            $error("module_name: LATENCY=%0d outside 0..%0d", LATENCY, MAX_LATENCY);
        end

        if (LATENCY == 0) begin : g_bypass
            // Pure wire: clock and reset have no influence on the output.
            logic unused_ok;
            assign unused_ok = ^{clk, rst_n};
            assign data_o    = data_i;
        end else begin : g_pipe
            // chain[0] is the input; chain[k] is the output of stage k-1.
            logic [WIDTH-1:0] chain [LATENCY+1];

            assign chain[0] = data_i;

            for (genvar k = 0; k < LATENCY; k++) begin : g_stage
                pipe_reg #(
                    .WIDTH     (WIDTH),
                    .RESET_VAL (RESET_VAL)
                ) u_reg (
                    .clk   (clk),
                    .rst_i (rst_n),
                    .d_i   (chain[k]),
                    .q_o   (chain[k+1])
                );
            end

            assign data_o = chain[LATENCY];
        end
    endgenerate

endmodule : module_name

// File: tb/tb_module_name.sv
// Scoreboard bench for module_name at LATENCY 2, 0 and 5 (WIDTH 8, nonzero reset value).
module tb_module_name;
    import tinyrv_pkg::*;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    word_t      d32;
    logic [7:0] d8;
    word_t      out2;
    word_t      out0;
    logic [7:0] out5;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    exp_t q2[$];
    exp_t q0[$];
    exp_t q5[$];

    module_name #(.WIDTH(32), .LATENCY(2), .RESET_VAL(32'h0)) dut2 (
        .clk(clk), .rst_n(rst), .data_i(d32), .data_o(out2));

    module_name #(.WIDTH(32), .LATENCY(0), .RESET_VAL(32'h0)) dut0 (
        .clk(clk), .rst_n(rst), .data_i(d32), .data_o(out0));

    module_name #(.WIDTH(8), .LATENCY(5), .RESET_VAL(8'h5A)) dut5 (
        .clk(clk), .rst_n(rst), .data_i(d8), .data_o(out5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        while (q2.size() > 0 && q2[0].due <= cyc) begin
            e = q2.pop_front();
            check("lat2_out", out2, e.val);
        end
        while (q0.size() > 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            check("lat0_out", out0, e.val);
        end
        while (q5.size() > 0 && q5[0].due <= cyc) begin
            e = q5.pop_front();
            check("lat5_out", {24'h0, out5}, e.val);
        end
    end

    // Drive one word for one cycle and record when each pipeline must show it.
    task automatic drive(input word_t w);
        d32 = w;
        d8  = w[7:0];
        q0.push_back('{due: cyc, val: w});
        if (!rst) begin
            q2.push_back('{due: cyc + 2, val: w});
            q5.push_back('{due: cyc + 5, val: {24'h0, w[7:0]}});
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, hold it for n edges, then release.
    task automatic reset_phase(input int n);
        q2.delete();
        q5.delete();
        d32 = 32'hFFFF_FFFF;
        d8  = 8'hFF;
        rst = 1'b1;
        #1;
        check("rst_async_lat2", out2, 32'h0);
        check("rst_async_lat5", {24'h0, out5}, 32'h5A);
        check("rst_bypass_lat0", out0, 32'hFFFF_FFFF);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_lat2", out2, 32'h0);
            check("rst_hold_lat5", {24'h0, out5}, 32'h5A);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) q2.push_back('{due: cyc + k, val: 32'h0});
        for (int k = 0; k < 5; k++) q5.push_back('{due: cyc + k, val: 32'h5A});
    endtask

    initial begin
        rst = 1'b0;
        d32 = '0;
        d8  = '0;
        #2;

        // Reset with all-ones input, then step response.
        reset_phase(1);
        repeat (4) drive(32'h0000_0001);

        // Slow sequence, each value held 10 cycles.
        for (int v = 1; v <= 4; v++) begin
            repeat (10) drive(word_t'(v));
        end

        // Back-to-back words, one per cycle.
        for (int i = 0; i < 10; i++) drive(32'hA5A5_0000 + word_t'(i));

        // Mid-run reset while DEAD_BEEF is in flight; it must never emerge.
        drive(32'hDEAD_BEEF);
        reset_phase(1);
        for (int i = 0; i < 8; i++) drive(32'h0000_0011 + word_t'(i));

        // Bit-exact extremes.
        drive(32'h8000_0001);
        drive(32'h7FFF_FFFE);
        drive(32'h0000_0000);
        drive(32'hFFFF_FFFF);

        // Drain with input frozen, bounded by a cycle budget.
        for (int i = 0; i < 12; i++) begin
            if (q2.size() == 0 && q5.size() == 0 && q0.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_lat2", q2.size(), 32'd0);
        check("drain_lat5", q5.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_module_name
